cnn_mac_pipe: RTL and testbench
===============================

CNN_MAC_PIPE -- requirements
Module: cnn_mac_pipe

Interface
REQ-001 The module SHALL have parameter ID, default 1, meaning instance tag with no functional effect.
REQ-002 The module SHALL have parameter A_WIDTH, default 25, meaning signed width of din0.
REQ-003 The module SHALL have parameter B_WIDTH, default 18, meaning signed width of din1.
REQ-004 The module SHALL have parameter ACC_WIDTH, default 48, meaning signed accumulator and dout width, legal only when ACC_WIDTH >= A_WIDTH+B_WIDTH.
REQ-005 The module SHALL have parameter NUM_STAGE, default 2, meaning multiplier register depth, legal range 1..4.
REQ-006 The module SHALL have port clk, input, 1 bit, meaning the single clock; one clock; all logic on rising edge.
REQ-007 The module SHALL have port reset_n, input, 1 bit, meaning reset, synchronous and active-low.
REQ-008 The module SHALL have port ce, input, 1 bit, meaning global clock enable; when 0, all state SHALL hold.
REQ-009 The module SHALL have port in_valid, input, 1 bit, meaning operand pair present.
REQ-010 The module SHALL have port in_ready, output, 1 bit, meaning operand pair accepted this cycle when in_valid is also 1.
REQ-011 The module SHALL have ports din0 (input, A_WIDTH, signed) and din1 (input, B_WIDTH, signed), meaning the operands.
REQ-012 The module SHALL have port in_last, input, 1 bit, meaning final pair of the current dot product.
REQ-013 The module SHALL have ports out_valid (output, 1), out_ready (input, 1), dout (output, ACC_WIDTH, signed) and out_sat (output, 1), meaning the result handshake, sum and overflow flag.

Function
REQ-014 Pipeline advance SHALL be adv = ce & (~out_valid | out_ready); in_ready SHALL equal adv.
REQ-015 On adv, din0*din1 (full A_WIDTH+B_WIDTH signed product) with its valid and last tags SHALL shift through NUM_STAGE registers; without adv, every stage SHALL hold.
REQ-016 Accumulator stage, on adv with a valid product: sum = (first ? 0 : acc) + sign-extended product; first SHALL be 1 after reset and after each last.
REQ-017 On a valid product tagged last, the module SHALL load dout with sum, set out_valid, and set first.
REQ-018 A handshake (out_valid & out_ready & ce) without a new result in the same cycle SHALL clear out_valid; a new result SHALL load in the same cycle without a bubble.
REQ-019 Latency: a pair with in_last accepted at edge t and no stalls SHALL give out_valid=1 after edge t+NUM_STAGE+1.
REQ-020 A single-pair dot product (in_last on the first pair) SHALL produce exactly that product.
REQ-021 Bubbles (in_valid=0) SHALL not disturb the partial sum.
REQ-022 In the default build, the sum SHALL wrap modulo 2^ACC_WIDTH and out_sat SHALL be constant 0.

Reset
REQ-023 While reset_n=0 at a clock edge, regardless of ce: all valid tags, out_valid, out_sat, acc and dout SHALL clear to 0, first SHALL be 1, and in-flight operands SHALL be discarded.
REQ-024 in_ready SHALL be 0 during reset and follow REQ-014 from the first edge after release.

Configuration
REQ-025 With macro CNN_MAC_SAT_EN defined, each accumulate SHALL clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], a sticky flag SHALL record any clamp within the dot product, and out_sat SHALL present that flag with dout (cleared at first).
REQ-026 Without CNN_MAC_SAT_EN, REQ-022 SHALL apply and no clamp logic SHALL be synthesised.

Structure
REQ-027 The package cnn_mac_pkg SHALL hold default width constants, the NUM_STAGE legal bounds and the saturation min/max helpers.
REQ-028 Sub-module cnn_mac_mul_pipe SHALL implement the NUM_STAGE-deep signed multiplier with tag shadow registers; accumulator, handshake and saturation stay at top level.

Verification
REQ-029 Defaults, pairs (3,4),(-5,6),(7,-8,last), no stalls -> one output dout=-74 three cycles after the last accept.
REQ-030 Single pair (-16777216,-131072,last) -> dout=2199023255552, out_sat=0.
REQ-031 out_ready=0 held 5 cycles while a result is pending -> in_ready=0, dout stable, no result lost; release -> next result follows back-to-back.
REQ-032 ce=0 for 3 cycles mid-stream -> all state held; final sum unchanged versus the ce=1 run.
REQ-033 ACC_WIDTH=43, pairs (2^24-1)*(2^17-1) x4 with CNN_MAC_SAT_EN -> dout=2^42-1, out_sat=1; without the macro -> wrapped value, out_sat=0.
REQ-034 reset_n=0 for 1 cycle after two of four pairs -> no output; new 2-pair stream (1,1),(2,2,last) -> dout=5.

Source files
------------

// File: rtl/cnn_mac_pkg.sv
// cnn_mac_pkg: shared constants and helpers for the CNN MAC pipeline.
//   - default operand / accumulator widths and multiplier depth
//   - legal NUM_STAGE bounds
//   - saturation bound helpers (results are wide; callers truncate to their
//     accumulator width, which yields 0111..1 / 1000..0 respectively)
package cnn_mac_pkg;

  localparam int A_WIDTH_DEF   = 25;
  localparam int B_WIDTH_DEF   = 18;
  localparam int ACC_WIDTH_DEF = 48;
  localparam int NUM_STAGE_DEF = 2;
  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;
  localparam int SAT_MAX_W     = 128;

  // Largest positive value of a w-bit signed number.
  function automatic logic [SAT_MAX_W-1:0] sat_max(input int unsigned w);
    return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
  endfunction

  // Most negative value of a w-bit signed number (valid in the low w bits).
  function automatic logic [SAT_MAX_W-1:0] sat_min(input int unsigned w);
    return SAT_MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// cnn_mac_mul_pipe: pipelined signed multiplier with valid/last shadow tags.
// Operands are captured in an input register, then the full-width product
// and its tags shift through NUM_STAGE registers. Everything advances only
// when adv is high; synchronous active-low reset clears all tags so any
// in-flight operands are discarded.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   adv                 pipeline advance enable
//   in_valid, in_last   tags for the operand pair
//   din0, din1          signed operands
//   p_valid, p_last     tags aligned with p_prod
//   p_prod              signed product, A_WIDTH+B_WIDTH bits
module cnn_mac_mul_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_WIDTH   = A_WIDTH_DEF,
  parameter int B_WIDTH   = B_WIDTH_DEF,
  parameter int NUM_STAGE = NUM_STAGE_DEF
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              adv,
  input  logic                              in_valid,
  input  logic                              in_last,
  input  logic signed [A_WIDTH-1:0]         din0,
  input  logic signed [B_WIDTH-1:0]         din1,
  output logic                              p_valid,
  output logic                              p_last,
  output logic signed [A_WIDTH+B_WIDTH-1:0] p_prod
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  logic signed [A_WIDTH-1:0] a_r;
  logic signed [B_WIDTH-1:0] b_r;
  logic                      op_valid;
  logic                      op_last;
  logic signed [P_WIDTH-1:0] prod_r [NUM_STAGE];
  logic [NUM_STAGE-1:0]      valid_r;
  logic [NUM_STAGE-1:0]      last_r;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_valid <= 1'b0;
      op_last  <= 1'b0;
      valid_r  <= '0;
      last_r   <= '0;
    end else if (adv) begin
      a_r        <= din0;
      b_r        <= din1;
      op_valid   <= in_valid;
      op_last    <= in_last;
      prod_r[0]  <= P_WIDTH'(a_r) * P_WIDTH'(b_r);
      valid_r[0] <= op_valid;
      last_r[0]  <= op_last;
      for (int unsigned i = 1; i < NUM_STAGE; i++) begin
        prod_r[i]  <= prod_r[i-1];
        valid_r[i] <= valid_r[i-1];
        last_r[i]  <= last_r[i-1];
      end
    end
  end

  assign p_valid = valid_r[NUM_STAGE-1];
  assign p_last  = last_r[NUM_STAGE-1];
  assign p_prod  = prod_r[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: streaming signed dot-product engine (multiply-accumulate).
// Operand pairs are accepted on in_valid & in_ready; the pair tagged in_last
// closes the dot product and its sum is presented on dout with out_valid
// until taken with out_ready. ce freezes all state when low.
// Optional build macro CNN_MAC_SAT_EN: clamp each accumulate to the signed
// ACC_WIDTH range and report any clamp within the dot product on out_sat.
// Without it the sum wraps and out_sat is constant 0.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   ce                      global clock enable
//   in_valid, in_ready      operand handshake
//   din0, din1, in_last     signed operands, end-of-dot-product tag
//   out_valid, out_ready    result handshake
//   dout, out_sat           result sum and saturation flag
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int ID        = 1,
  parameter int A_WIDTH   = A_WIDTH_DEF,
  parameter int B_WIDTH   = B_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int NUM_STAGE = NUM_STAGE_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ce,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [A_WIDTH-1:0]   din0,
  input  logic signed [B_WIDTH-1:0]   din1,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] dout,
  output logic                        out_sat
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  if (ID < 0 || NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX ||
      ACC_WIDTH < P_WIDTH) begin : g_bad_cfg
    $error("cnn_mac_pipe: illegal parameter combination");
  end

  logic                        adv;
  logic                        p_valid;
  logic                        p_last;
  logic signed [P_WIDTH-1:0]   p_prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        first;

  // A pending result blocks the whole pipe unless it is being taken now.
  assign adv      = ce & (~out_valid | out_ready);
  assign in_ready = adv & reset_n;

  cnn_mac_mul_pipe #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .NUM_STAGE(NUM_STAGE)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (adv),
    .in_valid(in_valid),
    .in_last (in_last),
    .din0    (din0),
    .din1    (din1),
    .p_valid (p_valid),
    .p_last  (p_last),
    .p_prod  (p_prod)
  );

  assign prod_ext = ACC_WIDTH'(p_prod);

`ifdef CNN_MAC_SAT_EN
  logic signed [ACC_WIDTH:0] wide;
  logic                      ovf;
  logic                      sticky;
  logic                      sat_next;
  logic                      sat_r;

  // One guard bit: overflow iff the two top bits of the wide sum differ.
  always_comb begin
    base = first ? '0 : acc;
    wide = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(prod_ext);
    ovf  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
    if (!ovf)                 sum = wide[ACC_WIDTH-1:0];
    else if (wide[ACC_WIDTH]) sum = ACC_WIDTH'(sat_min(ACC_WIDTH));
    else                      sum = ACC_WIDTH'(sat_max(ACC_WIDTH));
    sat_next = (~first & sticky) | ovf;
  end

  assign out_sat = sat_r;
`else
  always_comb begin
    base = first ? '0 : acc;
    sum  = base + prod_ext;
  end

  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      dout      <= '0;
`ifdef CNN_MAC_SAT_EN
      sticky    <= 1'b0;
      sat_r     <= 1'b0;
`endif
    end else if (adv) begin
      // adv with out_valid set implies out_ready: the result is taken now.
      // A new result below overrides this clear, so there is no bubble.
      if (out_valid) out_valid <= 1'b0;
      if (p_valid) begin
        acc   <= sum;
        first <= p_last;
`ifdef CNN_MAC_SAT_EN
        sticky <= sat_next;
`endif
        if (p_last) begin
          dout      <= sum;
          out_valid <= 1'b1;
`ifdef CNN_MAC_SAT_EN
          sat_r     <= sat_next;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_mac_pipe.sv
module tb_cnn_mac_pipe;

  logic               clk;
  logic               reset_n;
  logic               ce;
  logic               in_valid;
  logic               in_ready;
  logic signed [24:0] din0;
  logic signed [17:0] din1;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [47:0] dout;
  logic               out_sat;

  // Second instance with a narrow accumulator for the overflow case.
  logic               r1_in_valid;
  logic               r1_in_ready;
  logic signed [24:0] r1_din0;
  logic signed [17:0] r1_din1;
  logic               r1_in_last;
  logic               r1_out_valid;
  logic signed [42:0] r1_dout;
  logic               r1_out_sat;

  int total = 0;
  int bad   = 0;

  typedef struct {
    longint dout;
    bit     sat;
  } res_t;

  res_t   sbq[$];
  longint macc   = 0;
  bit     mfirst = 1'b1;
  bit     msat   = 1'b0;

  cnn_mac_pipe dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din0     (din0),
    .din1     (din1),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .out_sat  (out_sat)
  );

  cnn_mac_pipe #(.ID(2), .ACC_WIDTH(43)) dut43 (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (1'b1),
    .in_valid (r1_in_valid),
    .in_ready (r1_in_ready),
    .din0     (r1_din0),
    .din1     (r1_din1),
    .in_last  (r1_in_last),
    .out_valid(r1_out_valid),
    .out_ready(1'b1),
    .dout     (r1_dout),
    .out_sat  (r1_out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference accumulate step for a w-bit signed accumulator.
  function automatic longint acc_step(input int w, input longint base, input longint p,
                                      inout bit s);
    longint mx = (64'sd1 <<< (w - 1)) - 1;
    longint mn = -mx - 1;
    longint m  = 64'sd1 <<< w;
    longint r  = base + p;
`ifdef CNN_MAC_SAT_EN
    if (r > mx) begin r = mx; s = 1'b1; end
    else if (r < mn) begin r = mn; s = 1'b1; end
`else
    r = r & (m - 1);
    if (r > mx) r = r - m;
    if (r < mn) r = r + m;
`endif
    return r;
  endfunction

  // One clock for the main instance: check handshake, score results, update
  // the model on accepted pairs, then advance to the next falling edge.
  task automatic cyc(output bit took);
    logic   exp_rdy;
    longint r;
    bit     s;
    res_t   e;
    #1;
    exp_rdy = reset_n & ce & (~out_valid | out_ready);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (reset_n && ce && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'(0));
      else begin
        e = sbq.pop_front();
        chk("dout", {16'b0, dout}, {16'b0, 48'(e.dout)});
        chk("out_sat", 64'(out_sat), 64'(e.sat));
      end
    end
    took = in_valid && in_ready;
    if (took) begin
      s = mfirst ? 1'b0 : msat;
      r = acc_step(48, mfirst ? 64'sd0 : macc, longint'(din0) * longint'(din1), s);
      macc   = r;
      msat   = s;
      mfirst = in_last;
      if (in_last) sbq.push_back('{r, s});
    end
    if (!reset_n) begin
      macc = 0; msat = 1'b0; mfirst = 1'b1;
      sbq.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) cyc(t);
  endtask

  task automatic send(input longint a, input longint b, input bit last);
    bit t;
    int n = 0;
    din0 = 25'(a); din1 = 18'(b); in_last = last; in_valid = 1'b1;
    do begin cyc(t); n++; end while (!t && n < 50);
    if (!t) chk("send_timeout", 64'(t), 64'(1));
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(input int lim, output int k);
    bit t;
    k = 0;
    while (out_valid !== 1'b1 && k < lim) begin cyc(t); k++; end
    if (k >= lim) chk("wait_valid_timeout", 64'(out_valid), 64'(1));
  endtask

  initial begin : main
    bit          t;
    int          k;
    logic [47:0] hold;
    longint      r1acc;
    bit          r1s;

    reset_n = 1'b0; ce = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    din0 = '0; din1 = '0; out_ready = 1'b1;
    r1_in_valid = 1'b0; r1_in_last = 1'b0; r1_din0 = '0; r1_din1 = '0;
    @(negedge clk);
    idle(2);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_dout", {16'b0, dout}, 64'(0));
    chk("rst_out_sat", 64'(out_sat), 64'(0));
    chk("rst_r1_out_valid", 64'(r1_out_valid), 64'(0));
    reset_n = 1'b1;

    // basic dot product and latency
    send(3, 4, 0); send(-5, 6, 0); send(7, -8, 1);
    wait_valid(20, k);
    chk("latency", 64'(k), 64'(3));
    chk("dot3_dout", {16'b0, dout}, {16'b0, 48'(-74)});
    cyc(t);
    idle(2);

    // single pair, extreme negative operands
    send(-16777216, -131072, 1);
    wait_valid(20, k);
    chk("single_dout", {16'b0, dout}, 64'd2199023255552);
    cyc(t);

    // output backpressure
    send(1, 2, 1);
    wait_valid(20, k);
    out_ready = 1'b0;
    din0 = 3; din1 = 3; in_valid = 1'b1; in_last = 1'b0;
    hold = dout;
    for (int i = 0; i < 5; i++) begin
      cyc(t);
      chk("stall_dout", {16'b0, dout}, {16'b0, hold});
      chk("stall_valid", 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    send(3, 3, 0); send(1, 1, 1);
    wait_valid(20, k);
    cyc(t);

    // back-to-back results without a bubble
    send(2, 3, 1); send(4, 5, 1);
    wait_valid(20, k);
    cyc(t);
    chk("b2b_valid", 64'(out_valid), 64'(1));
    cyc(t);
    idle(2);

    // clock-enable freeze mid-stream and with a pending result
    send(3, 4, 0); send(-5, 6, 0);
    ce = 1'b0;
    din0 = 7; din1 = -8; in_valid = 1'b1; in_last = 1'b1;
    idle(3);
    chk("ce_no_output", 64'(out_valid), 64'(0));
    ce = 1'b1;
    send(7, -8, 1);
    wait_valid(20, k);
    ce = 1'b0;
    idle(2);
    chk("ce_hold_valid", 64'(out_valid), 64'(1));
    chk("ce_hold_dout", {16'b0, dout}, {16'b0, 48'(-74)});
    ce = 1'b1;
    cyc(t);

    // reset mid-stream discards partial sum and in-flight pairs
    send(9, 9, 0); send(9, 9, 0);
    reset_n = 1'b0;
    cyc(t);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(t);
      chk("post_rst_no_out", 64'(out_valid), 64'(0));
    end
    send(1, 1, 0); send(2, 2, 1);
    wait_valid(20, k);
    chk("post_rst_dout", {16'b0, dout}, 64'd5);
    cyc(t);

    // narrow accumulator overflow
    r1acc = 0; r1s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r1_din0 = 25'((64'sd1 <<< 24) - 1);
      r1_din1 = 18'((64'sd1 <<< 17) - 1);
      r1_in_valid = 1'b1; r1_in_last = (i == 3);
      #1;
      chk("r1_in_ready", 64'(r1_in_ready), 64'(1));
      r1acc = acc_step(43, r1acc, longint'(r1_din0) * longint'(r1_din1), r1s);
      cyc(t);
    end
    r1_in_valid = 1'b0; r1_in_last = 1'b0;
    k = 0;
    while (r1_out_valid !== 1'b1 && k < 20) begin cyc(t); k++; end
    chk("r1_out_valid", 64'(r1_out_valid), 64'(1));
    chk("r1_dout", {21'b0, r1_dout}, {21'b0, 43'(r1acc)});
    chk("r1_out_sat", 64'(r1_out_sat), 64'(r1s));
    idle(2);

    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
